mem_loader: RTL

Hardware program/data loader for the `microprocessor` core. It receives a framed byte stream on a valid/ready interface and writes 10-bit words into data RAM or 30-bit words into instruction memory. It holds the core stalled through `cpu_hold` while a frame is in flight. It is the write-side counterpart of the end-of-run data-RAM dump: it preloads the same RAM (14-bit address, 10-bit word) and the instruction store before execution.

---
 rtl/mem_loader_if.sv | 36 +++
 rtl/mem_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write bundle for the program/data loader.
// The slave view belongs to the loader, the master view to the stream source.
interface mem_loader_if #(
    parameter int AW = 14,
    parameter int DW = 10,
    parameter int IW = 30
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          instr_we;
    logic [AW-1:0] instr_addr;
    logic [IW-1:0] instr_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        output instr_we, instr_addr, instr_wdata,
        output cpu_hold, done, err
    );

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        input  instr_we, instr_addr, instr_wdata,
        input  cpu_hold, done, err
    );
endinterface

// File: rtl/mem_loader.sv
// Framed byte-stream loader that fills data RAM or instruction memory
// and holds the core stalled while a frame is in flight.
module mem_loader #(
    parameter int AW = 14,
    parameter int DW = 10,
    parameter int IW = 30
) (
    input  logic         clk,
    input  logic         rst,
    mem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CNT,
        PAYLOAD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          is_instr;
    logic [1:0]    bcnt;
    logic [AW-1:0] addr;
    logic [AW-1:0] remain;
    logic [23:0]   buffer;

    logic fire;
    logic hdr_ok;
    logic last_byte;
    logic cnt_zero;
    logic last_word;

    assign bus.in_ready = (state != DONE);
    assign bus.cpu_hold = (state != IDLE);

    assign fire      = bus.in_valid & bus.in_ready;
    assign hdr_ok    = (bus.in_data == 8'h01) | (bus.in_data == 8'h02);
    assign last_byte = is_instr ? (bcnt == 2'd3) : (bcnt == 2'd1);
    // Low count byte already sits in remain[7:0] when the high byte arrives.
    assign cnt_zero  = ({bus.in_data[AW-9:0], remain[7:0]} == '0);
    assign last_word = (remain == AW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Frame sequencing: header, two address bytes, two count bytes, payload.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fire && hdr_ok) state_nxt = ADDR;
            ADDR:    if (fire && bcnt[0]) state_nxt = CNT;
            CNT:     if (fire && bcnt[0]) state_nxt = cnt_zero ? DONE : PAYLOAD;
            PAYLOAD: if (fire && last_byte && last_word) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Field capture, word assembly and registered write/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_instr        <= 1'b0;
            bcnt            <= '0;
            addr            <= '0;
            remain          <= '0;
            buffer          <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.instr_we    <= 1'b0;
            bus.instr_addr  <= '0;
            bus.instr_wdata <= '0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.mem_we   <= 1'b0;
            bus.instr_we <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            if (fire) begin
                unique case (state)
                    IDLE: begin
                        is_instr <= bus.in_data[1];
                        bcnt     <= '0;
                        if (!hdr_ok) bus.err <= 1'b1;
                    end
                    ADDR: begin
                        if (bcnt[0]) addr[AW-1:8] <= bus.in_data[AW-9:0];
                        else         addr[7:0]    <= bus.in_data;
                        bcnt <= {1'b0, ~bcnt[0]};
                    end
                    CNT: begin
                        if (bcnt[0]) remain[AW-1:8] <= bus.in_data[AW-9:0];
                        else         remain[7:0]    <= bus.in_data;
                        if (bcnt[0] && cnt_zero) bus.done <= 1'b1;
                        bcnt <= {1'b0, ~bcnt[0]};
                    end
                    PAYLOAD: begin
                        if (last_byte) begin
                            if (is_instr) begin
                                bus.instr_we    <= 1'b1;
                                bus.instr_addr  <= addr;
                                bus.instr_wdata <= {bus.in_data[IW-25:0], buffer};
                            end else begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= addr;
                                bus.mem_wdata <= {bus.in_data[DW-9:0], buffer[7:0]};
                            end
                            addr   <= addr + AW'(1);
                            remain <= remain - AW'(1);
                            bcnt   <= '0;
                            if (last_word) bus.done <= 1'b1;
                        end else begin
                            buffer[8*bcnt +: 8] <= bus.in_data;
                            bcnt <= bcnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
